// File: rtl/pc_sequencer_if.sv
// Handshake bundle between the PC sequencer (slave) and its upstream decode/memory logic (master).
// PC_INSTR_COUNT_EN adds the INSTR_COUNT retired-instruction counter to the bundle.
interface pc_sequencer_if #(
  parameter int OFFSET_W = 8
);

  logic                BUSYWAIT;
  logic                JUMP;
  logic                BRANCH_EQ;
  logic                BRANCH_NE;
  logic                ZERO;
  logic [OFFSET_W-1:0] OFFSET;
  logic [31:0]         PC;
  logic [31:0]         PC_PLUS4;
  logic                PC_VALID;
  logic                STALLED;

`ifdef PC_INSTR_COUNT_EN
  logic [31:0]         INSTR_COUNT;

  modport master (
    output BUSYWAIT, JUMP, BRANCH_EQ, BRANCH_NE, ZERO, OFFSET,
    input  PC, PC_PLUS4, PC_VALID, STALLED, INSTR_COUNT
  );

  modport slave (
    input  BUSYWAIT, JUMP, BRANCH_EQ, BRANCH_NE, ZERO, OFFSET,
    output PC, PC_PLUS4, PC_VALID, STALLED, INSTR_COUNT
  );
`else
  modport master (
    output BUSYWAIT, JUMP, BRANCH_EQ, BRANCH_NE, ZERO, OFFSET,
    input  PC, PC_PLUS4, PC_VALID, STALLED
  );

  modport slave (
    input  BUSYWAIT, JUMP, BRANCH_EQ, BRANCH_NE, ZERO, OFFSET,
    output PC, PC_PLUS4, PC_VALID, STALLED
  );
`endif

endinterface

// File: rtl/pc_sequencer.sv
// Program-counter register and next-PC sequencer (BOOT/RUN/STALL) for the single-cycle CPU.
// Optional macro PC_INSTR_COUNT_EN enables the INSTR_COUNT retired-instruction counter.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          OFFSET_W = 8
) (
  input  logic           CLK,
  input  logic           RESET,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] pc;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] offset_sext;
  logic [31:0] redirect_target;
  logic [31:0] next_pc;
  logic        redirect;
  logic        advance;

  // Jump and taken branches share one target: word offset relative to PC+4, modulo 2^32.
  assign pc_plus4        = pc + 32'd4;
  assign offset_sext     = {{(32-OFFSET_W){bus.OFFSET[OFFSET_W-1]}}, bus.OFFSET};
  assign redirect_target = pc_plus4 + (offset_sext << 2);
  assign redirect        = bus.JUMP
                         | (bus.BRANCH_EQ &  bus.ZERO)
                         | (bus.BRANCH_NE & ~bus.ZERO);
  assign next_pc         = redirect ? redirect_target : pc_plus4;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= next_state;
      pc    <= pc_d;
    end
  end

  // BOOT holds RESET_PC for one full fetch cycle and ignores BUSYWAIT; a stall always suppresses the update.
  always_comb begin
    next_state = state;
    pc_d       = pc;
    advance    = 1'b0;
    case (state)
      BOOT: begin
        next_state = RUN;
      end
      RUN: begin
        if (bus.BUSYWAIT) begin
          next_state = STALL;
        end else begin
          pc_d    = next_pc;
          advance = 1'b1;
        end
      end
      STALL: begin
        if (!bus.BUSYWAIT) begin
          next_state = RUN;
          pc_d       = next_pc;
          advance    = 1'b1;
        end
      end
      default: begin
        next_state = BOOT;
        pc_d       = RESET_PC;
      end
    endcase
  end

  assign bus.PC       = pc;
  assign bus.PC_PLUS4 = pc_plus4;
  assign bus.PC_VALID = (state != BOOT);
  assign bus.STALLED  = (state == STALL);

`ifdef PC_INSTR_COUNT_EN
  logic [31:0] instr_count;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      instr_count <= 32'd0;
    end else if (advance) begin
      instr_count <= instr_count + 32'd1;
    end
  end

  assign bus.INSTR_COUNT = instr_count;
`else
  logic unused_advance;
  assign unused_advance = advance;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: boot, jumps, branches, stalls, async reset and address wrap.
// Build with +define+PC_INSTR_COUNT_EN to also check INSTR_COUNT.
module tb_pc_sequencer;

  logic clk;
  logic rst_n;
  logic rst_n_wrap;

  int test_count;
  int fail_count;

  pc_sequencer_if #(.OFFSET_W(8)) bus ();
  pc_sequencer_if #(.OFFSET_W(8)) bus_wrap ();

  pc_sequencer #(
    .RESET_PC (32'h0000_0000),
    .OFFSET_W (8)
  ) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus.slave)
  );

  pc_sequencer #(
    .RESET_PC (32'hFFFF_FFF8),
    .OFFSET_W (8)
  ) dut_wrap (
    .CLK   (clk),
    .RESET (rst_n_wrap),
    .bus   (bus_wrap.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic busywait, input logic jump, input logic beq,
                               input logic bne, input logic zero, input logic [7:0] offset);
    bus.BUSYWAIT  = busywait;
    bus.JUMP      = jump;
    bus.BRANCH_EQ = beq;
    bus.BRANCH_NE = bne;
    bus.ZERO      = zero;
    bus.OFFSET    = offset;
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef PC_INSTR_COUNT_EN
  logic [31:0] count_before;
`endif

  initial begin
    test_count = 0;
    fail_count = 0;
    rst_n      = 1'b0;
    rst_n_wrap = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    bus_wrap.BUSYWAIT  = 1'b0;
    bus_wrap.JUMP      = 1'b0;
    bus_wrap.BRANCH_EQ = 1'b0;
    bus_wrap.BRANCH_NE = 1'b0;
    bus_wrap.ZERO      = 1'b0;
    bus_wrap.OFFSET    = 8'h00;

    repeat (3) tick();
    checkOutput("reset_pc",      bus.PC,              32'h0000_0000);
    checkOutput("reset_valid",   {31'd0, bus.PC_VALID}, 32'd0);
    checkOutput("reset_stalled", {31'd0, bus.STALLED},  32'd0);
`ifdef PC_INSTR_COUNT_EN
    checkOutput("reset_count",   bus.INSTR_COUNT,     32'd0);
`endif

    rst_n = 1'b1;
    tick();
    checkOutput("boot_pc",    bus.PC,                32'h0000_0000);
    checkOutput("boot_valid", {31'd0, bus.PC_VALID}, 32'd1);
`ifdef PC_INSTR_COUNT_EN
    checkOutput("boot_count", bus.INSTR_COUNT,       32'd0);
`endif
    tick();
    checkOutput("seq_pc_4",   bus.PC,       32'h0000_0004);
    tick();
    checkOutput("seq_pc_8",   bus.PC,       32'h0000_0008);
    checkOutput("plus4_8",    bus.PC_PLUS4, 32'h0000_000C);
    tick();
    tick();
    checkOutput("seq_pc_10",  bus.PC,       32'h0000_0010);

    // Jump back by two words: 0x14 - 8.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFE);
    tick();
    checkOutput("jump_neg",   bus.PC, 32'h0000_000C);

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFE);
    tick();
    checkOutput("jump_wins",  bus.PC, 32'h0000_0008);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h05);
    tick();
    checkOutput("jump_pos",   bus.PC, 32'h0000_0020);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h03);
    tick();
    checkOutput("beq_taken",  bus.PC, 32'h0000_0030);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFB);
    tick();
    checkOutput("jump_back",  bus.PC, 32'h0000_0020);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h03);
    tick();
    checkOutput("beq_not_taken", bus.PC, 32'h0000_0024);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01);
    tick();
    checkOutput("bne_taken",  bus.PC, 32'h0000_002C);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01);
    tick();
    checkOutput("bne_not_taken", bus.PC, 32'h0000_0030);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h03);
    tick();
    checkOutput("jump_to_40", bus.PC, 32'h0000_0040);
`ifdef PC_INSTR_COUNT_EN
    count_before = bus.INSTR_COUNT;
    checkOutput("count_run",  count_before, 32'd13);
`endif

    // Stall with a pending jump: redirect lands only on the release edge.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("stall_pc_%0d", i),      bus.PC,                32'h0000_0040);
      checkOutput($sformatf("stall_flag_%0d", i),    {31'd0, bus.STALLED},  32'd1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02);
    tick();
    checkOutput("stall_release_pc",   bus.PC,               32'h0000_004C);
    checkOutput("stall_release_flag", {31'd0, bus.STALLED}, 32'd0);
`ifdef PC_INSTR_COUNT_EN
    checkOutput("stall_count_delta",  bus.INSTR_COUNT,      count_before + 32'd1);
`endif

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    checkOutput("stall2_pc",   bus.PC,               32'h0000_004C);
    checkOutput("stall2_flag", {31'd0, bus.STALLED}, 32'd1);

    // Asynchronous reset between edges while stalled.
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_pc",      bus.PC,                32'h0000_0000);
    checkOutput("async_rst_stalled", {31'd0, bus.STALLED},  32'd0);
    checkOutput("async_rst_valid",   {31'd0, bus.PC_VALID}, 32'd0);
`ifdef PC_INSTR_COUNT_EN
    checkOutput("async_rst_count",   bus.INSTR_COUNT,       32'd0);
`endif
    tick();
    checkOutput("rst_hold_pc",       bus.PC,                32'h0000_0000);
    #2;
    rst_n = 1'b1;

    // BUSYWAIT is still high: BOOT must ignore it.
    tick();
    checkOutput("reboot_pc",      bus.PC,                32'h0000_0000);
    checkOutput("reboot_valid",   {31'd0, bus.PC_VALID}, 32'd1);
    checkOutput("reboot_stalled", {31'd0, bus.STALLED},  32'd0);
    tick();
    checkOutput("reboot_stall_pc",   bus.PC,               32'h0000_0000);
    checkOutput("reboot_stall_flag", {31'd0, bus.STALLED}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    checkOutput("reboot_release_pc", bus.PC, 32'h0000_0004);
`ifdef PC_INSTR_COUNT_EN
    checkOutput("reboot_count",      bus.INSTR_COUNT, 32'd1);
`endif

    // Wrap-around instance.
    checkOutput("wrap_reset_pc",    bus_wrap.PC,                32'hFFFF_FFF8);
    checkOutput("wrap_reset_valid", {31'd0, bus_wrap.PC_VALID}, 32'd0);
    rst_n_wrap = 1'b1;
    tick();
    checkOutput("wrap_boot_pc",  bus_wrap.PC,       32'hFFFF_FFF8);
    tick();
    checkOutput("wrap_pc_fffc",  bus_wrap.PC,       32'hFFFF_FFFC);
    checkOutput("wrap_plus4",    bus_wrap.PC_PLUS4, 32'h0000_0000);
    tick();
    checkOutput("wrap_pc_zero",  bus_wrap.PC,       32'h0000_0000);
`ifdef PC_INSTR_COUNT_EN
    checkOutput("wrap_count",    bus_wrap.INSTR_COUNT, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
